// File: rtl/mult_seq_param_if.sv
// Operand/result bundle for the sequential multiplier.
// The source drives valid/operands; the multiplier returns ready and results.
interface mult_seq_param_if #(
  parameter int WIDTH = 8
);
  logic               valid;
  logic               ready;
  logic               signed_mode;
  logic [WIDTH-1:0]   num_1;
  logic [WIDTH-1:0]   num_2;
  logic               mult_done;
  logic               mult_sign;
  logic [2*WIDTH-1:0] mult_result;

  modport master (
    output valid, signed_mode, num_1, num_2,
    input  ready, mult_done, mult_sign, mult_result
  );

  modport slave (
    input  valid, signed_mode, num_1, num_2,
    output ready, mult_done, mult_sign, mult_result
  );
endinterface

// File: rtl/mult_seq_param.sv
// Parametrised shift-add multiplier, one operation in flight.
// Operands are reduced to magnitudes; the sign is applied on result load.
module mult_seq_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic           clk,
  input logic           rst,
  mult_seq_param_if.slave bus
);
  localparam int RW = 2*WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ready_c;
  logic             done_c;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] abs_1;
  logic [WIDTH-1:0] abs_2;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    acc_nx;
  logic [RW-1:0]    res_q;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;
  logic             sgn_q;
  logic             last;

  // Most negative value negates to itself, which is the right magnitude.
  assign abs_1 = (bus.signed_mode && bus.num_1[WIDTH-1])
               ? -bus.num_1 : bus.num_1;
  assign abs_2 = (bus.signed_mode && bus.num_2[WIDTH-1])
               ? -bus.num_2 : bus.num_2;

  assign acc_nx = mag_b[0]
                ? acc + ({{WIDTH{1'b0}}, mag_a} << cnt)
                : acc;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_r <= 1'b0;
      res_q  <= '0;
      sgn_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid) begin
            mag_a  <= abs_1;
            mag_b  <= abs_2;
            sign_r <= bus.signed_mode
                    & (bus.num_1[WIDTH-1] ^ bus.num_2[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + CNT_W'(1);
          // Zero product is always reported positive.
          if (last) begin
            res_q <= acc_nx;
            sgn_q <= sign_r & (acc_nx != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = ready_c;
  assign bus.mult_done   = done_c;
  assign bus.mult_result = res_q;
  assign bus.mult_sign   = sgn_q;
endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: 8-bit and 16-bit instances against
// an integer-arithmetic reference model.
module tb_mult_seq_param;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mult_seq_param_if #(.WIDTH(8))  b8();
  mult_seq_param_if #(.WIDTH(16)) b16();

  mult_seq_param #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  mult_seq_param #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  function automatic void model(
    input  int              w,
    input  bit              s,
    input  longint unsigned a,
    input  longint unsigned b,
    output longint unsigned mag,
    output bit              neg
  );
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    p   = x * y;
    neg = (p < 0);
    mag = neg ? longint'(-p) : longint'(p);
  endfunction

  task automatic run8(
    input  bit          s,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] res,
    output bit          sg,
    output int          lat,
    output int          rlow,
    output bit          held,
    output bit          idle_after
  );
    logic [15:0] prev;
    int g;
    @(negedge clk);
    b8.valid = 1'b1;
    b8.signed_mode = s;
    b8.num_1 = a;
    b8.num_2 = b;
    g = 0;
    while (b8.ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    prev = b8.mult_result;
    @(posedge clk);
    #1;
    b8.valid = 1'b0;
    b8.num_1 = 8'($urandom);
    b8.num_2 = 8'($urandom);
    b8.signed_mode = 1'($urandom);
    lat = 0;
    rlow = 0;
    held = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (b8.ready === 1'b0) rlow++;
      if (b8.mult_done === 1'b1) break;
      if (b8.mult_result !== prev) held = 1'b0;
    end
    res = b8.mult_result;
    sg = b8.mult_sign;
    @(negedge clk);
    idle_after = (b8.ready === 1'b1) && (b8.mult_done === 1'b0)
              && (b8.mult_result === res);
  endtask

  task automatic run16(
    input  bit           s,
    input  logic [15:0]  a,
    input  logic [15:0]  b,
    output logic [31:0]  res,
    output bit           sg,
    output int           lat
  );
    int g;
    @(negedge clk);
    b16.valid = 1'b1;
    b16.signed_mode = s;
    b16.num_1 = a;
    b16.num_2 = b;
    g = 0;
    while (b16.ready !== 1'b1 && g < 80) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    b16.valid = 1'b0;
    b16.num_1 = 16'($urandom);
    b16.num_2 = 16'($urandom);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (b16.mult_done === 1'b1) break;
    end
    res = b16.mult_result;
    sg = b16.mult_sign;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b8.valid = 1'b0;
    b8.signed_mode = 1'b0;
    b8.num_1 = '0;
    b8.num_2 = '0;
    b16.valid = 1'b0;
    b16.signed_mode = 1'b0;
    b16.num_1 = '0;
    b16.num_2 = '0;
    #1;
    total_cnt++;
    if ({b8.ready, b8.mult_done, b8.mult_sign} !== 3'b100) begin
      $display("FAIL reset_ctrl8: got %b want 100",
               {b8.ready, b8.mult_done, b8.mult_sign});
    end else pass_cnt++;
    total_cnt++;
    if (b8.mult_result !== 16'd0) begin
      $display("FAIL reset_res8: got %0d want 0", b8.mult_result);
    end else pass_cnt++;
    total_cnt++;
    if ({b16.ready, b16.mult_done, b16.mult_sign, b16.mult_result}
        !== {3'b100, 32'd0}) begin
      $display("FAIL reset_16: got r%b d%b s%b res%0d want r1 d0 s0 res0",
               b16.ready, b16.mult_done, b16.mult_sign, b16.mult_result);
    end else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    bit          ts[7] = '{0, 1, 1, 1, 0, 1, 1};
    logic [7:0]  ta[7] = '{8'd3, 8'hFD, 8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h00};
    logic [7:0]  tb[7] = '{8'd4, 8'd4, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFB};
    logic [15:0] em[7] = '{16'd12, 16'd12, 16'd16384, 16'd16256,
                           16'd65025, 16'd1, 16'd0};
    bit          es[7] = '{0, 1, 0, 1, 0, 0, 0};
    logic [15:0] res;
    bit sg, held, idl;
    int lat, rlow;
    for (int i = 0; i < 7; i++) begin
      run8(ts[i], ta[i], tb[i], res, sg, lat, rlow, held, idl);
      total_cnt++;
      if (res !== em[i]) begin
        $display("FAIL dir_res[%0d]: got %0d want %0d", i, res, em[i]);
      end else pass_cnt++;
      total_cnt++;
      if (sg !== es[i]) begin
        $display("FAIL dir_sign[%0d]: got %0d want %0d", i, sg, es[i]);
      end else pass_cnt++;
      total_cnt++;
      if (lat != 9) begin
        $display("FAIL dir_latency[%0d]: got %0d want 9", i, lat);
      end else pass_cnt++;
      total_cnt++;
      if (rlow != 9) begin
        $display("FAIL dir_ready_low[%0d]: got %0d want 9", i, rlow);
      end else pass_cnt++;
      total_cnt++;
      if (!held || !idl) begin
        $display("FAIL dir_hold[%0d]: got held=%0d idle=%0d want 1 1",
                 i, held, idl);
      end else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    bit s, sg, held, idl, en;
    logic [15:0] res;
    longint unsigned m;
    int lat, rlow;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      model(8, s, a, b, m, en);
      run8(s, a, b, res, sg, lat, rlow, held, idl);
      total_cnt++;
      if (res !== 16'(m) || sg !== en) begin
        $display("FAIL rand_prod[%0d]: s=%0d %0d*%0d got %0d/%0d want %0d/%0d",
                 i, s, a, b, res, sg, m, en);
      end else pass_cnt++;
      total_cnt++;
      if (!held || lat != 9) begin
        $display("FAIL rand_timing[%0d]: got held=%0d lat=%0d want 1 9",
                 i, held, lat);
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] em[$];
    bit es[$];
    int hs[$];
    int n, ndone, cyc, herr;
    logic [15:0] last;
    logic [7:0] a, b;
    bit s, en;
    longint unsigned m;
    n = 0;
    ndone = 0;
    cyc = 0;
    herr = 0;
    @(negedge clk);
    last = b8.mult_result;
    b8.valid = 1'b1;
    while (cyc < 200 && ndone < 6) begin
      if (b8.mult_done === 1'b1) begin
        total_cnt++;
        if (em.size() == 0) begin
          $display("FAIL b2b_extra_done: got done at cycle %0d want none", cyc);
        end else begin
          m = longint'(em.pop_front());
          en = es.pop_front();
          if (b8.mult_result !== 16'(m) || b8.mult_sign !== en) begin
            $display("FAIL b2b_prod[%0d]: got %0d/%0d want %0d/%0d",
                     ndone, b8.mult_result, b8.mult_sign, m, en);
          end else pass_cnt++;
        end
        last = b8.mult_result;
        ndone++;
      end else if (b8.mult_result !== last) begin
        herr++;
      end
      if (b8.ready === 1'b1) begin
        if (n < 6) begin
          a = 8'($urandom);
          b = 8'($urandom);
          s = 1'($urandom);
          b8.num_1 = a;
          b8.num_2 = b;
          b8.signed_mode = s;
          model(8, s, a, b, m, en);
          em.push_back(16'(m));
          es.push_back(en);
          hs.push_back(cyc);
          n++;
        end else begin
          b8.valid = 1'b0;
        end
      end else begin
        b8.num_1 = 8'($urandom);
        b8.num_2 = 8'($urandom);
        b8.signed_mode = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    b8.valid = 1'b0;
    total_cnt++;
    if (ndone != 6) begin
      $display("FAIL b2b_count: got %0d dones want 6", ndone);
    end else pass_cnt++;
    total_cnt++;
    if (herr != 0) begin
      $display("FAIL b2b_hold: got %0d result changes want 0", herr);
    end else pass_cnt++;
    for (int i = 1; i < hs.size(); i++) begin
      total_cnt++;
      if (hs[i] - hs[i-1] != 10) begin
        $display("FAIL b2b_spacing[%0d]: got %0d want 10",
                 i, hs[i] - hs[i-1]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_midrun_reset();
    logic [15:0] res;
    bit sg, held, idl, seen;
    int lat, rlow, g;
    run8(0, 8'd7, 8'd9, res, sg, lat, rlow, held, idl);
    total_cnt++;
    if (res !== 16'd63) begin
      $display("FAIL rst_pre: got %0d want 63", res);
    end else pass_cnt++;
    @(negedge clk);
    b8.valid = 1'b1;
    b8.signed_mode = 1'b0;
    b8.num_1 = 8'd5;
    b8.num_2 = 8'd6;
    g = 0;
    while (b8.ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    b8.valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({b8.ready, b8.mult_done, b8.mult_sign} !== 3'b100
        || b8.mult_result !== 16'd0) begin
      $display("FAIL rst_async: got r%b d%b s%b res%0d want r1 d0 s0 res0",
               b8.ready, b8.mult_done, b8.mult_sign, b8.mult_result);
    end else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (b8.mult_done === 1'b1 || b8.mult_result !== 16'd0) seen = 1'b1;
    end
    total_cnt++;
    if (seen) begin
      $display("FAIL rst_no_done: got done/result activity want none");
    end else pass_cnt++;
    run8(0, 8'd5, 8'd6, res, sg, lat, rlow, held, idl);
    total_cnt++;
    if (res !== 16'd30 || sg !== 1'b0 || lat != 9) begin
      $display("FAIL rst_after: got %0d/%0d lat %0d want 30/0 lat 9",
               res, sg, lat);
    end else pass_cnt++;
  endtask

  task automatic test_wide();
    logic [31:0] res;
    logic [15:0] a, b;
    bit sg, s, en;
    int lat;
    longint unsigned m;
    run16(0, 16'd40000, 16'd3, res, sg, lat);
    total_cnt++;
    if (res !== 32'd120000 || sg !== 1'b0) begin
      $display("FAIL w16_unsigned: got %0d/%0d want 120000/0", res, sg);
    end else pass_cnt++;
    total_cnt++;
    if (lat != 17) begin
      $display("FAIL w16_latency: got %0d want 17", lat);
    end else pass_cnt++;
    run16(1, 16'h8000, 16'd2, res, sg, lat);
    total_cnt++;
    if (res !== 32'd65536 || sg !== 1'b1) begin
      $display("FAIL w16_signed: got %0d/%0d want 65536/1", res, sg);
    end else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      model(16, s, a, b, m, en);
      run16(s, a, b, res, sg, lat);
      total_cnt++;
      if (res !== 32'(m) || sg !== en || lat != 17) begin
        $display("FAIL w16_rand[%0d]: got %0d/%0d lat %0d want %0d/%0d lat 17",
                 i, res, sg, lat, m, en);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midrun_reset();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
- Parametrised sequential shift-add multiplier; next generation of the 8-bit multiplier top.
- Adds:
  - a generic operand width;
  - a runtime signed/unsigned mode;
  - a valid/ready input handshake;
  - a one-cycle done pulse;
  - held sign-magnitude result outputs.
- Sits between operand source logic and result consumers (display/UART path). Fixed latency, one operation in flight.

Parameters:
- WIDTH, 8, operand width in bits (WIDTH >= 2); result magnitude is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- valid  input  1  operands and signed_mode are valid this cycle.
- ready  output  1  block idle and accepting; handshake occurs when valid && ready at a rising edge.
- signed_mode  input  1  1: num_1/num_2 are two's complement; 0: unsigned.
- num_1  input  WIDTH  multiplicand.
- num_2  input  WIDTH  multiplier.
- mult_done  output  1  one-cycle pulse; result registers updated this cycle.
- mult_sign  output  1  sign of product (1 = negative).
- mult_result  output  2*WIDTH  magnitude of product.

Behaviour:
- Reset (rst=0, any time, including mid-operation), asynchronous:
  - state=IDLE, ready=1, mult_done=0, mult_sign=0, mult_result=0.
  - Counter, accumulator and operand registers all cleared.
  - No partial result is ever exposed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On handshake at edge E0:
    - mag_a=|num_1|, mag_b=|num_2|; absolute value taken only if signed_mode=1 and MSB=1, else raw.
    - sign_r = signed_mode & (num_1[MSB] ^ num_2[MSB]).
    - acc=0, cnt=0, go RUN.
    - Inputs are not sampled again until the next handshake.
- Magnitudes are WIDTH-bit unsigned. The most negative value -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
- RUN:
  - ready=0. Each edge: if mag_b[0], acc += mag_a << cnt (2*WIDTH-bit add, no carry out possible); mag_b >>= 1; cnt++.
  - Leave RUN on the edge where cnt reaches WIDTH (edge E_WIDTH). That edge enters DONE and loads mult_result=acc_final and mult_sign=sign_r & (acc_final != 0).
- Zero product always reports mult_sign=0.
- DONE:
  - ready=0, mult_done=1 for exactly this cycle.
  - Next edge returns to IDLE, mult_done=0, ready=1.
- Latency:
  - mult_done high during the cycle following edge E0+WIDTH.
  - Next handshake is possible at edge E0+WIDTH+2 at the earliest.
  - Throughput: one product per WIDTH+2 cycles.
- valid while ready=0: ignored, no queueing. The source must hold valid until a handshake occurs.
- mult_result/mult_sign hold their value from one DONE until the next DONE or reset; they never change in IDLE/RUN.
- Simultaneous valid in the DONE cycle: not accepted (ready=0). It is accepted in the following IDLE cycle if still asserted.
- Unsigned mode: mult_sign is always 0; full-range operands, e.g. (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (WIDTH=8 unless stated):
- Unsigned 3*4, valid at E0 → mult_done pulses 1 cycle after E0+8; mult_result=12, sign=0; ready low 9 cycles.
- Signed -3 (0xFD) * 4 → result=12, sign=1. Signed -128*-128 → result=16384, sign=0. Signed 127*-128 → result=16256, sign=1.
- Unsigned 255*255 → result=65025, sign=0. Same bits signed (-1*-1) → result=1, sign=0.
- Signed 0 * -5 → result=0, sign=0 (zero forces positive).
- Back-to-back: valid held high continuously with new operands each handshake:
  - handshakes are exactly 10 cycles apart;
  - operands changed mid-RUN do not affect the result;
  - the previous result is held until the next mult_done.
- Reset: assert rst=0 at cycle 4 of RUN during 5*6 → all outputs 0 immediately (async), no mult_done. After release, 5*6 → 30 with normal latency.
- WIDTH=16 instance: 40000*3 unsigned → 120000; -32768*2 signed → 65536, sign=1; latency 16+1 edges.
